// File: rtl/butterfly_sprite_fetch.sv
// rtl/butterfly_sprite_fetch.sv - butterfly sprite hit test, ROM address issue and colour index realignment
// Three-stage pixel pipeline: address + box flags, ROM read, registered palette index and hit.
module butterfly_sprite_fetch #(
  parameter int          W           = 32,
  parameter int          H           = 32,
  parameter int          FRAMES      = 4,
  parameter int          FRAME_DIV   = 8,
  parameter logic [3:0]  TRANSPARENT = 4'h0,
  parameter int          ADDR_W      = $clog2(FRAMES*W*H)
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              vs,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic              flip_x,
  input  logic              anim_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        palette_index,
  output logic              sprite_hit
);

  localparam int LX_W    = $clog2(W);
  localparam int LY_W    = (H > 1) ? $clog2(H) : 1;
  localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int DIV_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(FRAME_DIV - 1);
  localparam logic [ADDR_W-1:0]  FRAME_SZ   = ADDR_W'(W * H);

  logic               vs_q;
  logic               frame_start;
  logic [9:0]         sx, sy;
  logic               fx;
  logic [DIV_W-1:0]   div_cnt;
  logic [FRAME_W-1:0] frame_idx;

  logic               inbox;
  logic [LX_W-1:0]    lx_raw, lx;
  logic [LY_W-1:0]    ly;
  logic [ADDR_W-1:0]  addr_next;

  logic               inbox1, blank1, inbox2, blank2;

  assign frame_start = vs_q & ~vs;

  // Position, flip and animation state only change on the vsync falling edge.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      vs_q      <= 1'b1;
      sx        <= '0;
      sy        <= '0;
      fx        <= 1'b0;
      div_cnt   <= '0;
      frame_idx <= '0;
    end else begin
      vs_q <= vs;
      if (frame_start) begin
        sx <= sprite_x;
        sy <= sprite_y;
        fx <= flip_x;
        if (anim_en) begin
          if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            frame_idx <= (frame_idx == FRAME_LAST) ? '0 : frame_idx + FRAME_W'(1);
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
      end
    end
  end

  // 11-bit compares so a sprite near the right/bottom edge clips instead of wrapping to column 0.
  always_comb begin
    inbox = ({1'b0, DrawX} >= {1'b0, sx}) && ({1'b0, DrawX} < ({1'b0, sx} + 11'(W))) &&
            ({1'b0, DrawY} >= {1'b0, sy}) && ({1'b0, DrawY} < ({1'b0, sy} + 11'(H)));
    lx_raw    = LX_W'(DrawX - sx);
    ly        = LY_W'(DrawY - sy);
    lx        = fx ? (LX_W'(W - 1) - lx_raw) : lx_raw;
    addr_next = ADDR_W'(frame_idx) * FRAME_SZ + ADDR_W'({ly, lx});
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_addr      <= '0;
      inbox1        <= 1'b0;
      blank1        <= 1'b0;
      inbox2        <= 1'b0;
      blank2        <= 1'b0;
      palette_index <= 4'h0;
      sprite_hit    <= 1'b0;
    end else begin
      if (inbox) rom_addr <= addr_next;
      inbox1        <= inbox;
      blank1        <= blank;
      inbox2        <= inbox1;
      blank2        <= blank1;
      palette_index <= rom_q;
      sprite_hit    <= inbox2 & blank2 & (rom_q != TRANSPARENT);
    end
  end

endmodule

// File: doc/butterfly_sprite_fetch.md
# butterfly_sprite_fetch

Upstream pixel stage for the butterfly sprite. It compares the current VGA raster position against the sprite's latched screen position and issues the sprite-sheet ROM address for the current animation frame. It then realigns the returned 4-bit colour index with a hit flag. The `palette_index` output drives the butterfly palette lookup directly. `sprite_hit` tells the colour mapper whether to show the palette colour or the background.

## Interface
Parameters:
- `W`, 32: sprite width in pixels (power of two).
- `H`, 32: sprite height in pixels.
- `FRAMES`, 4: animation frames stored back-to-back in ROM.
- `FRAME_DIV`, 8: vsync periods per animation frame (≥1).
- `TRANSPARENT`, 4'h0: index treated as see-through.
- `ADDR_W`, $clog2(FRAMES*W*H): ROM address width.

Ports:
- `vga_clk` input 1: pixel clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-high.
- `DrawX` input 10: current pixel column, 0–799.
- `DrawY` input 10: current pixel row, 0–524.
- `blank` input 1: high while in the visible region.
- `vs` input 1: vertical sync, active-low.
- `sprite_x` input 10: requested top-left column.
- `sprite_y` input 10: requested top-left row.
- `flip_x` input 1: mirror sprite horizontally.
- `anim_en` input 1: allow animation frames to advance.
- `rom_addr` output ADDR_W: registered sprite-sheet address.
- `rom_q` input 4: ROM data. Synchronous read, valid one clock after `rom_addr` is registered.
- `palette_index` output 4: colour index to the palette.
- `sprite_hit` output 1: pixel is inside the sprite, visible, and opaque.

## Operation
- **Frame-start event:** `vs` sampled into a register. The event is the cycle where the registered value is 1 and the current `vs` is 0 (falling edge). One event per frame.
- **On each frame-start event:**
  - Latch `sprite_x`, `sprite_y` and `flip_x` into `sx`, `sy`, `fx`. Position and flip never change mid-frame.
  - If `anim_en`=1: increment `div_cnt`. When `div_cnt`=FRAME_DIV-1, clear it and set `frame_idx` ← (`frame_idx`+1) mod FRAMES.
  - If `anim_en`=0: `div_cnt` and `frame_idx` hold.
- **In-box test:** DrawX ≥ sx && DrawX < sx+W && DrawY ≥ sy && DrawY < sy+H.
  - Computed in 11 bits, so a sprite hanging off the right or bottom edge is clipped, never wrapped.
- **Local coordinates:**
  - lx = DrawX−sx, ly = DrawY−sy.
  - If fx=1, lx ← W−1−lx.
- **Address:** `rom_addr` = frame_idx·W·H + ly·W + lx.
  - Outside the box, the address holds its previous value; it is don't-care there, but must not toggle needlessly.
- **Pipeline stages:**
  - S1 registers `rom_addr`, `inbox1`, `blank1`.
  - S2 registers `inbox2`, `blank2`; `rom_q` is valid during S2.
  - S3 registers outputs: `palette_index` ← rom_q; `sprite_hit` ← inbox2 & blank2 & (rom_q ≠ TRANSPARENT).
- When `sprite_hit`=0, `palette_index` still carries `rom_q`; the consumer must ignore it.

## Timing
- **Latency:** three clocks from a DrawX/DrawY sample to the matching `palette_index`/`sprite_hit`. The consumer delays its background path by 3 to match.
- **Throughput:** one pixel per clock, no stalls, no handshake.
- **`frame_idx` timing:** the new value affects addresses from the cycle after the event onward. It reaches the outputs 3 clocks after that.
- **Reset (asynchronous):** all of the following clear immediately:
  - `rom_addr`=0, `palette_index`=0, `sprite_hit`=0.
  - `frame_idx`=0, `div_cnt`=0.
  - `sx`=`sy`=0, `fx`=0.
  - Pipeline flags = 0.
  - Registered `vs` = 1, so a low `vs` at release counts as a frame-start event.
- **Reset mid-frame:** no hit is asserted until a pixel is fed after release. The sprite sits at 0,0 until the next frame-start event.
- **Simultaneous events:** a frame-start event and an in-box pixel in the same cycle use the old `sx`/`sy`/`frame_idx` for that pixel. Vsync lies in the blanking interval, so this has no visible effect.
- **Wrap-around:** `frame_idx` wraps FRAMES−1 → 0. `div_cnt` never exceeds FRAME_DIV−1.

## Test plan
- **Basic hit:** sprite_x=100, sprite_y=50, one vs pulse. Feed DrawX=100, DrawY=50, blank=1.
  - Next cycle: `rom_addr`=0.
  - With rom_q=5: `palette_index`=5 and `sprite_hit`=1 exactly 3 clocks after the input.
- **Edges and transparency:** with the same setup:
  - DrawX=131, DrawY=81 → `rom_addr`=1023.
  - DrawX=132 → `sprite_hit`=0.
  - rom_q=0 at an inside pixel → `sprite_hit`=0.
- **Flip:** flip_x=1 latched. DrawX=100, DrawY=50 → `rom_addr`=31. DrawX=131 → `rom_addr`=0.
- **Animation:** anim_en=1 for 8 vs pulses. `frame_idx` → 1 and `rom_addr` at the sprite origin = 1024. After 32 pulses it wraps back to 0. With anim_en=0, the count holds.
- **Clipping:** sprite_x=620. DrawX=639 → hit (lx=19). DrawX=0 with DrawY inside the box → no hit, no wrap.
- **Reset:** assert reset mid-line while `sprite_hit`=1. Outputs go 0 without a clock edge. After release, the sprite is at 0,0 with frame 0.
